// File: rtl/rd_arb_pkg.sv
// Shared state encoding and default sizing for the round-robin read-port arbiter.
// Latency: none; this file holds declarations only.
// Backpressure: not applicable.
package rd_arb_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int ADDR_W_DEF   = 8;
    localparam int WAIT_MAX_DEF = 15;

    // One-hot read-cycle states.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        READ = 4'b0010,
        DLY  = 4'b0100,
        DONE = 4'b1000
    } state_t;

endpackage

// File: rtl/rd_arb_ctrl_if.sv
// Requester/memory bundle for the read-port arbiter; timeout_err exists only with RD_TIMEOUT_EN.
// Latency: wires only.
// Backpressure: requests are level-held until done; the memory stalls a cycle with ws.
interface rd_arb_ctrl_if
    import rd_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic [NREQ-1:0]        req;
    logic [NREQ*ADDR_W-1:0] addr_in;
    logic                   ws;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   rd;
    logic                   ds;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   busy;
`ifdef RD_TIMEOUT_EN
    logic                   timeout_err;
`endif

    // Requesters plus memory side: drive requests and wait state, observe strobes.
    modport master (
        output req, addr_in, ws,
        input  gnt, done, rd, ds, mem_addr, busy
`ifdef RD_TIMEOUT_EN
        , timeout_err
`endif
    );

    // Arbiter/sequencer side.
    modport slave (
        input  req, addr_in, ws,
        output gnt, done, rd, ds, mem_addr, busy
`ifdef RD_TIMEOUT_EN
        , timeout_err
`endif
    );

endinterface

// File: rtl/rr_picker.sv
// Round-robin priority search: first asserted req at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the winner.
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic [PTR_W-1:0] win_idx,
    output logic             win_vld
);

    logic [PTR_W-1:0] idx;

    // Scan from the pointer upward and keep the first hit.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PTR_W'((int'(ptr) + i) % NREQ);
            if (!win_vld && req[idx]) begin
                win_vld     = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/rd_arb_ctrl.sv
// Round-robin arbiter + IDLE/READ/DLY/DONE sequencer sharing one wait-stated read port; RD_TIMEOUT_EN adds a loop timeout.
// Latency: grant to done is 3 edges plus one wait loop (2 edges) per ws=1 sample in DLY, then one forced IDLE cycle.
// Backpressure: ws=1 in DLY re-enters READ; requests stay pending (level) until their done pulse.
module rd_arb_ctrl
    import rd_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int WAIT_MAX = WAIT_MAX_DEF
) (
    input  logic         clk,
    input  logic         reset,
    rd_arb_ctrl_if.slave bus
);

    localparam int PTR_W = $clog2(NREQ);

    // Reject configurations outside the supported range at elaboration.
    if (NREQ < 2 || NREQ > 8 || WAIT_MAX < 1) begin : g_param_chk
        $error("rd_arb_ctrl: NREQ must be 2..8 and WAIT_MAX >= 1");
    end

    state_t            state;
    logic [NREQ-1:0]   gnt_q;
    logic [NREQ-1:0]   done_q;
    logic              rd_q;
    logic              ds_q;
    logic              busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [PTR_W-1:0]  ptr;

    logic [NREQ-1:0]   win_oh;
    logic [PTR_W-1:0]  win_idx;
    logic              win_vld;
    logic [ADDR_W-1:0] win_addr;
    logic [PTR_W-1:0]  ptr_nxt;

`ifdef RD_TIMEOUT_EN
    localparam int CNT_W = (WAIT_MAX < 16) ? 4 : $clog2(WAIT_MAX + 1);
    logic [CNT_W-1:0]  loop_cnt;
    logic              timeout_q;
    assign bus.timeout_err = timeout_q;
`endif

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req     (bus.req),
        .ptr     (ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Select the winner's address slice.
    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_addr = bus.addr_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign ptr_nxt = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    // Read-cycle FSM; every output is a flop loaded from next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            rd_q       <= 1'b0;
            ds_q       <= 1'b0;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
            ptr        <= '0;
`ifdef RD_TIMEOUT_EN
            loop_cnt   <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state      <= READ;
                        gnt_q      <= win_oh;
                        mem_addr_q <= win_addr;
                        rd_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        ptr        <= ptr_nxt;
`ifdef RD_TIMEOUT_EN
                        loop_cnt   <= '0;
`endif
                    end
                end
                READ: begin
                    state <= DLY;
                end
                DLY: begin
                    if (bus.ws) begin
`ifdef RD_TIMEOUT_EN
                        if (loop_cnt == CNT_W'(WAIT_MAX)) begin
                            state     <= DONE;
                            rd_q      <= 1'b0;
                            done_q    <= gnt_q;
                            timeout_q <= 1'b1;
                        end else begin
                            state    <= READ;
                            loop_cnt <= loop_cnt + 1'b1;
                        end
`else
                        state <= READ;
`endif
                    end else begin
                        state  <= DONE;
                        rd_q   <= 1'b0;
                        ds_q   <= 1'b1;
                        done_q <= gnt_q;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    ds_q   <= 1'b0;
                    done_q <= '0;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
`ifdef RD_TIMEOUT_EN
                    timeout_q <= 1'b0;
`endif
                end
                default: begin
                    state  <= IDLE;
                    rd_q   <= 1'b0;
                    ds_q   <= 1'b0;
                    done_q <= '0;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rd       = rd_q;
    assign bus.ds       = ds_q;
    assign bus.busy     = busy_q;
    assign bus.mem_addr = mem_addr_q;

endmodule

// File: tb/tb_rd_arb_ctrl.sv
// Scoreboard bench for rd_arb_ctrl; covers RD_TIMEOUT_EN when the macro is defined.
// Latency: checks grant-to-done edge counts and grant spacing.
// Backpressure: ws is driven to stretch DLY loops.
module tb_rd_arb_ctrl;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 8;
`ifdef RD_TIMEOUT_EN
    localparam int WM = 3;
`else
    localparam int WM = 15;
`endif

    typedef struct packed {
        logic [NREQ-1:0]   done;
        logic [ADDR_W-1:0] addr;
        logic              tmo;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tmo_obs;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    rd_arb_ctrl_if #(.NREQ(NREQ), .ADDR_W(ADDR_W)) bus ();

    rd_arb_ctrl #(
        .NREQ     (NREQ),
        .ADDR_W   (ADDR_W),
        .WAIT_MAX (WM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef RD_TIMEOUT_EN
    assign tmo_obs = bus.timeout_err;
`else
    assign tmo_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic test_reset();
        bus.req = '0; bus.addr_in = '0; bus.ws = 1'b0; reset = 1'b1;
        #10;
        n_vec++; if (bus.gnt !== 4'b0 || bus.done !== 4'b0) begin n_err++; $display("FAIL reset_gnt_done got %b/%b want 0000/0000", bus.gnt, bus.done); end
        n_vec++; if (bus.rd !== 1'b0 || bus.ds !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_strobes got rd=%b ds=%b busy=%b want 0", bus.rd, bus.ds, bus.busy); end
        n_vec++; if (bus.mem_addr !== 8'h00 || tmo_obs !== 1'b0) begin n_err++; $display("FAIL reset_addr_tmo got %h/%b want 00/0", bus.mem_addr, tmo_obs); end
        #6 reset = 1'b0;
        @(negedge clk); @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin n_err++; $display("FAIL idle_hold got busy=%b gnt=%b want 0/0000", bus.busy, bus.gnt); end
    endtask

    task automatic test_single();
        exp_t e; int rd_cyc = 0; int g_cyc = 0; bit seen = 1'b0;
        bus.addr_in = '0; bus.addr_in[7:0] = 8'h3C; bus.ws = 1'b0; bus.req = 4'b0001;
        sb.push_back(exp_t'{done: 4'b0001, addr: 8'h3C, tmo: 1'b0});
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(negedge clk);
            if (bus.rd) rd_cyc++;
            if (bus.gnt != 4'b0) g_cyc++;
            if (bus.done != 4'b0) begin
                seen = 1'b1; bus.req = '0; e = sb.pop_front();
                n_vec++; if (bus.done !== e.done) begin n_err++; $display("FAIL single_done got %b want %b", bus.done, e.done); end
                n_vec++; if (bus.mem_addr !== e.addr) begin n_err++; $display("FAIL single_addr got %h want %h", bus.mem_addr, e.addr); end
                n_vec++; if (bus.ds !== 1'b1) begin n_err++; $display("FAIL single_ds got %b want 1", bus.ds); end
                n_vec++; if (k !== 3) begin n_err++; $display("FAIL single_latency got %0d want 3", k); end
                n_vec++; if (rd_cyc !== 2) begin n_err++; $display("FAIL single_rd_cycles got %0d want 2", rd_cyc); end
            end
        end
        if (!seen) begin n_vec++; n_err++; bus.req = '0; void'(sb.pop_front()); $display("FAIL single_timeout got no done want done within 12 cycles"); end
        @(negedge clk);
        n_vec++; if (bus.ds !== 1'b0 || bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL single_after got ds=%b gnt=%b busy=%b want 0", bus.ds, bus.gnt, bus.busy); end
        n_vec++; if (g_cyc !== 3) begin n_err++; $display("FAIL single_gnt_cycles got %0d want 3", g_cyc); end
    endtask

    task automatic test_ws_stretch();
        exp_t e; int rd_cyc = 0; bit seen = 1'b0;
        bus.addr_in[7:0] = 8'hA5; bus.ws = 1'b1; bus.req = 4'b0001;
        sb.push_back(exp_t'{done: 4'b0001, addr: 8'hA5, tmo: 1'b0});
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.rd) rd_cyc++;
            if (k == 1) bus.addr_in[7:0] = 8'h11;
            if (k == 6) bus.ws = 1'b0;
            if (bus.done != 4'b0) begin
                seen = 1'b1; bus.req = '0; e = sb.pop_front();
                n_vec++; if (bus.done !== e.done) begin n_err++; $display("FAIL ws_done got %b want %b", bus.done, e.done); end
                n_vec++; if (bus.mem_addr !== e.addr) begin n_err++; $display("FAIL ws_addr_capture got %h want %h", bus.mem_addr, e.addr); end
                n_vec++; if (k !== 7) begin n_err++; $display("FAIL ws_latency got %0d want 7", k); end
                n_vec++; if (rd_cyc !== 6) begin n_err++; $display("FAIL ws_rd_contiguous got %0d want 6", rd_cyc); end
                n_vec++; if (bus.ds !== 1'b1) begin n_err++; $display("FAIL ws_ds got %b want 1", bus.ds); end
            end
        end
        if (!seen) begin n_vec++; n_err++; bus.req = '0; bus.ws = 1'b0; void'(sb.pop_front()); $display("FAIL ws_timeout got no done want done within 20 cycles"); end
        @(negedge clk);
        n_vec++; if (bus.ds !== 1'b0) begin n_err++; $display("FAIL ws_ds_width got %b want 0", bus.ds); end
    endtask

    task automatic test_reset_mid();
        exp_t e; bit seen = 1'b0;
        bus.addr_in = '0; bus.addr_in[7:0] = 8'h5A; bus.addr_in[15:8] = 8'h6B;
        bus.ws = 1'b1; bus.req = 4'b0011;
        @(negedge clk);
        n_vec++; if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL mid_pre_gnt got %b want 0010", bus.gnt); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++; if (bus.rd !== 1'b0 || bus.gnt !== 4'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_abort got rd=%b gnt=%b busy=%b want 0", bus.rd, bus.gnt, bus.busy); end
        n_vec++; if (bus.done !== 4'b0) begin n_err++; $display("FAIL mid_no_done got %b want 0000", bus.done); end
        @(negedge clk);
        reset = 1'b0; bus.ws = 1'b0;
        sb.push_back(exp_t'{done: 4'b0001, addr: 8'h5A, tmo: 1'b0});
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_vec++; if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL mid_regrant got %b want 0001", bus.gnt); end
            end
            if (bus.done != 4'b0) begin
                seen = 1'b1; bus.req = '0; e = sb.pop_front();
                n_vec++; if (bus.done !== e.done) begin n_err++; $display("FAIL mid_done got %b want %b", bus.done, e.done); end
                n_vec++; if (bus.mem_addr !== e.addr) begin n_err++; $display("FAIL mid_addr got %h want %h", bus.mem_addr, e.addr); end
                n_vec++; if (k !== 3) begin n_err++; $display("FAIL mid_latency got %0d want 3", k); end
            end
        end
        if (!seen) begin n_vec++; n_err++; bus.req = '0; void'(sb.pop_front()); $display("FAIL mid_timeout got no done want done within 12 cycles"); end
        @(negedge clk);
    endtask

    task automatic test_rr_all();
        exp_t e; int ndone = 0; int last_g = 0; logic [NREQ-1:0] prev_gnt = '0;
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        bus.addr_in = {8'h44, 8'h33, 8'h22, 8'h11}; bus.ws = 1'b0; bus.req = 4'b1111;
        sb.push_back(exp_t'{done: 4'b0001, addr: 8'h11, tmo: 1'b0});
        sb.push_back(exp_t'{done: 4'b0010, addr: 8'h22, tmo: 1'b0});
        sb.push_back(exp_t'{done: 4'b0100, addr: 8'h33, tmo: 1'b0});
        sb.push_back(exp_t'{done: 4'b1000, addr: 8'h44, tmo: 1'b0});
        sb.push_back(exp_t'{done: 4'b0001, addr: 8'h11, tmo: 1'b0});
        for (int k = 1; k <= 40 && ndone < 5; k++) begin
            @(negedge clk);
            if (bus.gnt != 4'b0 && prev_gnt == 4'b0) begin
                if (last_g > 0) begin
                    n_vec++; if (k - last_g !== 4) begin n_err++; $display("FAIL rr_spacing got %0d want 4", k - last_g); end
                end
                last_g = k;
            end
            prev_gnt = bus.gnt;
            if (bus.done != 4'b0) begin
                e = sb.pop_front(); ndone++;
                if (ndone == 5) bus.req = '0;
                n_vec++; if (bus.done !== e.done || bus.gnt !== e.done) begin n_err++; $display("FAIL rr_order got done=%b gnt=%b want %b", bus.done, bus.gnt, e.done); end
                n_vec++; if (bus.mem_addr !== e.addr) begin n_err++; $display("FAIL rr_addr got %h want %h", bus.mem_addr, e.addr); end
            end
        end
        n_vec++; if (ndone !== 5) begin n_err++; bus.req = '0; sb.delete(); $display("FAIL rr_count got %0d want 5", ndone); end
        @(negedge clk);
    endtask

    task automatic test_ptr2();
        exp_t e; int ndone = 0;
        bus.addr_in = {8'h00, 8'h88, 8'h77, 8'h99}; bus.ws = 1'b0; bus.req = 4'b0010;
        sb.push_back(exp_t'{done: 4'b0010, addr: 8'h77, tmo: 1'b0});
        sb.push_back(exp_t'{done: 4'b0100, addr: 8'h88, tmo: 1'b0});
        sb.push_back(exp_t'{done: 4'b0001, addr: 8'h99, tmo: 1'b0});
        for (int k = 1; k <= 40 && ndone < 3; k++) begin
            @(negedge clk);
            if (bus.done != 4'b0) begin
                e = sb.pop_front(); ndone++;
                n_vec++; if (bus.done !== e.done) begin n_err++; $display("FAIL ptr2_order got %b want %b", bus.done, e.done); end
                n_vec++; if (bus.mem_addr !== e.addr) begin n_err++; $display("FAIL ptr2_addr got %h want %h", bus.mem_addr, e.addr); end
                if (ndone == 1) bus.req = 4'b0101;
                else bus.req = bus.req & ~bus.done;
            end
        end
        n_vec++; if (ndone !== 3) begin n_err++; bus.req = '0; sb.delete(); $display("FAIL ptr2_count got %0d want 3", ndone); end
        @(negedge clk);
    endtask

`ifdef RD_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e; int rd_cyc = 0; bit seen = 1'b0;
        bus.addr_in = '0; bus.addr_in[7:0] = 8'hE1; bus.ws = 1'b1; bus.req = 4'b0001;
        sb.push_back(exp_t'{done: 4'b0001, addr: 8'hE1, tmo: 1'b1});
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(negedge clk);
            if (bus.rd) rd_cyc++;
            if (bus.done != 4'b0) begin
                seen = 1'b1; bus.req = '0; bus.ws = 1'b0; e = sb.pop_front();
                n_vec++; if (bus.done !== e.done) begin n_err++; $display("FAIL tmo_done got %b want %b", bus.done, e.done); end
                n_vec++; if (tmo_obs !== e.tmo) begin n_err++; $display("FAIL tmo_flag got %b want %b", tmo_obs, e.tmo); end
                n_vec++; if (bus.ds !== 1'b0) begin n_err++; $display("FAIL tmo_ds got %b want 0", bus.ds); end
                n_vec++; if (k !== 9) begin n_err++; $display("FAIL tmo_latency got %0d want 9", k); end
                n_vec++; if (rd_cyc !== 8) begin n_err++; $display("FAIL tmo_rd_cycles got %0d want 8", rd_cyc); end
            end
        end
        if (!seen) begin n_vec++; n_err++; bus.req = '0; bus.ws = 1'b0; void'(sb.pop_front()); $display("FAIL tmo_expired got no done want done within 30 cycles"); end
        @(negedge clk);
        n_vec++; if (tmo_obs !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 4'b0) begin n_err++; $display("FAIL tmo_after got tmo=%b busy=%b done=%b want 0", tmo_obs, bus.busy, bus.done); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_ws_stretch();
        test_reset_mid();
        test_rr_all();
        test_ptr2();
`ifdef RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no completion want finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
